// File: rtl/bruteforce_job_ctrl_if.sv
// Job descriptor handshake between the host/config side and bruteforce_job_ctrl.
interface bruteforce_job_ctrl_if;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [5:0] cfg_start_offset;
    logic [3:0] cfg_max_chars;
    logic [6:0] cfg_charset_size;

    modport master (output cfg_valid, cfg_start_offset, cfg_max_chars, cfg_charset_size,
                    input  cfg_ready);
    modport slave  (input  cfg_valid, cfg_start_offset, cfg_max_chars, cfg_charset_size,
                    output cfg_ready);
endinterface

// File: rtl/bruteforce_job_ctrl.sv
// Job sequencer for one char_gen + hash-compare lane: load, run, drain, report.
// Optional BF_STOP_ON_HIT_EN: the first valid hit ends the job early (not flagged as aborted).
module bruteforce_job_ctrl #(
    parameter int PIPE_LATENCY   = 64,
    parameter int GEN_RST_CYCLES = 2
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    bruteforce_job_ctrl_if.slave    cfg,
    input  logic                    i_abort,
    input  logic                    i_gen_finished,
    input  logic                    i_hit,
    output logic                    o_gen_reset,
    output logic [5:0]              o_gen_start_offset,
    output logic [3:0]              o_gen_max_characters,
    output logic [6:0]              o_gen_charset_size,
    output logic                    o_busy,
    output logic                    o_done,
    output logic                    o_found,
    output logic                    o_aborted,
    output logic                    o_cfg_err,
    output logic [63:0]             o_found_counter,
    output logic [15:0]             o_hit_count
);
    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RUN, S_DRAIN, S_DONE} state_t;

    localparam logic [31:0] LOAD_LAST  = 32'(GEN_RST_CYCLES - 1);
    localparam logic [31:0] DRAIN_LAST = 32'(PIPE_LATENCY - 1);
    localparam logic [63:0] LAT64      = 64'(PIPE_LATENCY);

    state_t      r_state, w_state_n;
    logic [31:0] r_cnt;
    logic [63:0] r_k;
    logic        r_cfg_ready, r_gen_reset, r_busy, r_done, r_found, r_aborted, r_cfg_err;
    logic [5:0]  r_off;
    logic [3:0]  r_mc;
    logic [6:0]  r_cs;
    logic [63:0] r_fc;
    logic [15:0] r_hc;

    logic        w_found_n, w_aborted_n, w_cfg_err_n;
    logic [5:0]  w_off_n;
    logic [3:0]  w_mc_n;
    logic [6:0]  w_cs_n;
    logic [63:0] w_fc_n;
    logic [15:0] w_hc_n;

    logic w_hs, w_bad, w_act, w_hit_v, w_abort, w_stop;

    assign w_hs    = cfg.cfg_valid & r_cfg_ready;
    assign w_bad   = (cfg.cfg_charset_size < 7'd2) || (cfg.cfg_max_chars == 4'd0);
    assign w_act   = (r_state == S_RUN) || (r_state == S_DRAIN);
    // retire_idx = k - PIPE_LATENCY only exists once the pipe has filled
    assign w_hit_v = w_act && (r_k >= LAT64) && i_hit;
    assign w_abort = i_abort && (r_state inside {S_LOAD, S_RUN, S_DRAIN});
`ifdef BF_STOP_ON_HIT_EN
    assign w_stop  = w_hit_v;
`else
    assign w_stop  = 1'b0;
`endif

    always_comb begin
        w_state_n   = r_state;
        w_found_n   = r_found;
        w_aborted_n = r_aborted;
        w_cfg_err_n = r_cfg_err;
        w_off_n     = r_off;
        w_mc_n      = r_mc;
        w_cs_n      = r_cs;
        w_fc_n      = r_fc;
        w_hc_n      = r_hc;
        case (r_state)
            S_IDLE:  if (w_hs) w_state_n = w_bad ? S_DONE : S_LOAD;
            S_LOAD:  if (r_cnt == LOAD_LAST) w_state_n = S_RUN;
            S_RUN:   if (i_gen_finished) w_state_n = S_DRAIN;
            S_DRAIN: if (r_cnt == DRAIN_LAST) w_state_n = S_DONE;
            S_DONE:  w_state_n = S_IDLE;
            default: w_state_n = S_IDLE;
        endcase
        if (w_abort || w_stop) w_state_n = S_DONE;

        if (w_hs) begin
            w_off_n     = cfg.cfg_start_offset;
            w_mc_n      = cfg.cfg_max_chars;
            w_cs_n      = cfg.cfg_charset_size;
            w_found_n   = 1'b0;
            w_aborted_n = 1'b0;
            w_cfg_err_n = w_bad;
            w_fc_n      = '0;
            w_hc_n      = '0;
        end
        // a hit coinciding with abort is still recorded
        if (w_hit_v) begin
            if (!r_found) begin
                w_found_n = 1'b1;
                w_fc_n    = r_k - LAT64;
            end
            if (r_hc != 16'hFFFF) w_hc_n = r_hc + 16'd1;
        end
        if (w_abort) w_aborted_n = 1'b1;
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_k         <= '0;
            r_cfg_ready <= 1'b0;
            r_gen_reset <= 1'b1;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_found     <= 1'b0;
            r_aborted   <= 1'b0;
            r_cfg_err   <= 1'b0;
            r_off       <= '0;
            r_mc        <= '0;
            r_cs        <= '0;
            r_fc        <= '0;
            r_hc        <= '0;
        end else begin
            r_state     <= w_state_n;
            r_cnt       <= (w_state_n != r_state) ? 32'd0 : r_cnt + 32'd1;
            r_k         <= (r_state == S_LOAD) ? 64'd0 : (w_act ? r_k + 64'd1 : r_k);
            r_cfg_ready <= (w_state_n == S_IDLE);
            r_gen_reset <= !((w_state_n == S_RUN) || (w_state_n == S_DRAIN));
            r_busy      <= (w_state_n != S_IDLE);
            r_done      <= (w_state_n == S_DONE);
            r_found     <= w_found_n;
            r_aborted   <= w_aborted_n;
            r_cfg_err   <= w_cfg_err_n;
            r_off       <= w_off_n;
            r_mc        <= w_mc_n;
            r_cs        <= w_cs_n;
            r_fc        <= w_fc_n;
            r_hc        <= w_hc_n;
        end
    end

    assign cfg.cfg_ready            = r_cfg_ready;
    assign o_gen_reset              = r_gen_reset;
    assign o_gen_start_offset       = r_off;
    assign o_gen_max_characters     = r_mc;
    assign o_gen_charset_size       = r_cs;
    assign o_busy                   = r_busy;
    assign o_done                   = r_done;
    assign o_found                  = r_found;
    assign o_aborted                = r_aborted;
    assign o_cfg_err                = r_cfg_err;
    assign o_found_counter          = r_fc;
    assign o_hit_count              = r_hc;
endmodule
